// File: rtl/execute_unit_mc.sv
// execute_unit_mc: multi-cycle execute stage (ALU, branch/JALR, load/store lanes).
// Define EXU_MDU_EN to build the iterative multiply/divide engine; otherwise M ops are ignored.

`ifndef ID_ADD
`define ID_ADD    1
`define ID_SUB    2
`define ID_SLL    3
`define ID_SLT    4
`define ID_SLTU   5
`define ID_XOR    6
`define ID_SRL    7
`define ID_SRA    8
`define ID_OR     9
`define ID_AND    10
`define ID_ADDI   11
`define ID_SLTI   12
`define ID_SLTIU  13
`define ID_XORI   14
`define ID_ORI    15
`define ID_ANDI   16
`define ID_SLLI   17
`define ID_SRLI   18
`define ID_SRAI   19
`define ID_LUI    20
`define ID_AUIPC  21
`define ID_JAL    22
`define ID_JALR   23
`define ID_BEQ    24
`define ID_BNE    25
`define ID_BLT    26
`define ID_BGE    27
`define ID_BLTU   28
`define ID_BGEU   29
`define ID_LB     30
`define ID_LH     31
`define ID_LW     32
`define ID_LBU    33
`define ID_LHU    34
`define ID_SB     35
`define ID_SH     36
`define ID_SW     37
`define ID_MUL    38
`define ID_MULH   39
`define ID_MULHSU 40
`define ID_MULHU  41
`define ID_DIV    42
`define ID_DIVU   43
`define ID_REM    44
`define ID_REMU   45
`endif

module execute_unit_mc #(
  parameter int              XLEN   = 32,
  parameter int              IDW    = 6,
  parameter logic [XLEN-1:0] PC_RST = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  output logic              in_rdy,
  input  logic              flush,
  input  logic [IDW-1:0]    instID,
  input  logic [XLEN-1:0]   x_rs1,
  input  logic [XLEN-1:0]   x_rs2,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  output logic              ex_jmp_vld,
  output logic [XLEN-1:0]   ex_jmp_addr,
  output logic              ex_rd_vld,
  output logic [XLEN-1:0]   ex_rd,
  output logic [XLEN-1:0]   ex_mem_addr,
  output logic [XLEN/8-1:0] ex_mem_rden,
  output logic [XLEN/8-1:0] ex_mem_wren,
  output logic [XLEN-1:0]   ex_mem_wrdata,
  output logic [1:0]        ex_ld_sext,
  output logic              ex_misalign,
  output logic              busy
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int SHW  = $clog2(XLEN);

  logic accept;
  assign accept = in_vld && in_rdy && !flush;

  logic [XLEN-1:0] sum_ri, br_tgt, link;
  logic [SHW-1:0]  sh_r, sh_i;
  assign sum_ri = x_rs1 + imm;
  assign br_tgt = pc + imm;
  assign link   = pc + XLEN'(4);
  assign sh_r   = x_rs2[SHW-1:0];
  assign sh_i   = imm[SHW-1:0];

  logic            n_rd_vld, n_jmp_vld;
  logic [XLEN-1:0] n_rd, n_jmp_addr;
  logic            mem_op, mem_st;
  logic [1:0]      mem_sz, mem_fmt;

  always_comb begin
    n_rd_vld   = 1'b0;
    n_rd       = '0;
    n_jmp_vld  = 1'b0;
    n_jmp_addr = br_tgt;
    mem_op     = 1'b0;
    mem_st     = 1'b0;
    mem_sz     = 2'd0;
    mem_fmt    = 2'd0;
    case (instID)
      IDW'(`ID_ADD):   begin n_rd_vld = 1'b1; n_rd = x_rs1 + x_rs2; end
      IDW'(`ID_SUB):   begin n_rd_vld = 1'b1; n_rd = x_rs1 - x_rs2; end
      IDW'(`ID_SLL):   begin n_rd_vld = 1'b1; n_rd = x_rs1 << sh_r; end
      IDW'(`ID_SLT):   begin n_rd_vld = 1'b1; n_rd = XLEN'($signed(x_rs1) < $signed(x_rs2)); end
      IDW'(`ID_SLTU):  begin n_rd_vld = 1'b1; n_rd = XLEN'(x_rs1 < x_rs2); end
      IDW'(`ID_XOR):   begin n_rd_vld = 1'b1; n_rd = x_rs1 ^ x_rs2; end
      IDW'(`ID_SRL):   begin n_rd_vld = 1'b1; n_rd = x_rs1 >> sh_r; end
      IDW'(`ID_SRA):   begin n_rd_vld = 1'b1; n_rd = $signed(x_rs1) >>> sh_r; end
      IDW'(`ID_OR):    begin n_rd_vld = 1'b1; n_rd = x_rs1 | x_rs2; end
      IDW'(`ID_AND):   begin n_rd_vld = 1'b1; n_rd = x_rs1 & x_rs2; end
      IDW'(`ID_ADDI):  begin n_rd_vld = 1'b1; n_rd = sum_ri; end
      IDW'(`ID_SLTI):  begin n_rd_vld = 1'b1; n_rd = XLEN'($signed(x_rs1) < $signed(imm)); end
      IDW'(`ID_SLTIU): begin n_rd_vld = 1'b1; n_rd = XLEN'(x_rs1 < imm); end
      IDW'(`ID_XORI):  begin n_rd_vld = 1'b1; n_rd = x_rs1 ^ imm; end
      IDW'(`ID_ORI):   begin n_rd_vld = 1'b1; n_rd = x_rs1 | imm; end
      IDW'(`ID_ANDI):  begin n_rd_vld = 1'b1; n_rd = x_rs1 & imm; end
      IDW'(`ID_SLLI):  begin n_rd_vld = 1'b1; n_rd = x_rs1 << sh_i; end
      IDW'(`ID_SRLI):  begin n_rd_vld = 1'b1; n_rd = x_rs1 >> sh_i; end
      IDW'(`ID_SRAI):  begin n_rd_vld = 1'b1; n_rd = $signed(x_rs1) >>> sh_i; end
      IDW'(`ID_LUI):   begin n_rd_vld = 1'b1; n_rd = imm; end
      IDW'(`ID_AUIPC): begin n_rd_vld = 1'b1; n_rd = br_tgt; end
      IDW'(`ID_JAL):   begin n_rd_vld = 1'b1; n_rd = link; end
      IDW'(`ID_JALR): begin
        n_rd_vld   = 1'b1;
        n_rd       = link;
        n_jmp_vld  = 1'b1;
        n_jmp_addr = {sum_ri[XLEN-1:1], 1'b0};
      end
      IDW'(`ID_BEQ):   n_jmp_vld = (x_rs1 == x_rs2);
      IDW'(`ID_BNE):   n_jmp_vld = (x_rs1 != x_rs2);
      IDW'(`ID_BLT):   n_jmp_vld = ($signed(x_rs1) < $signed(x_rs2));
      IDW'(`ID_BGE):   n_jmp_vld = ($signed(x_rs1) >= $signed(x_rs2));
      IDW'(`ID_BLTU):  n_jmp_vld = (x_rs1 < x_rs2);
      IDW'(`ID_BGEU):  n_jmp_vld = (x_rs1 >= x_rs2);
      IDW'(`ID_LB):    begin mem_op = 1'b1; mem_sz = 2'd0; mem_fmt = 2'd1; end
      IDW'(`ID_LH):    begin mem_op = 1'b1; mem_sz = 2'd1; mem_fmt = 2'd1; end
      IDW'(`ID_LW):    begin mem_op = 1'b1; mem_sz = 2'd2; mem_fmt = 2'd0; end
      IDW'(`ID_LBU):   begin mem_op = 1'b1; mem_sz = 2'd0; mem_fmt = 2'd2; end
      IDW'(`ID_LHU):   begin mem_op = 1'b1; mem_sz = 2'd1; mem_fmt = 2'd2; end
      IDW'(`ID_SB):    begin mem_op = 1'b1; mem_st = 1'b1; mem_sz = 2'd0; end
      IDW'(`ID_SH):    begin mem_op = 1'b1; mem_st = 1'b1; mem_sz = 2'd1; end
      IDW'(`ID_SW):    begin mem_op = 1'b1; mem_st = 1'b1; mem_sz = 2'd2; end
      default: ;
    endcase
  end

  // Lane enables follow the byte offset; a misaligned access raises no enables at all.
  logic            misal;
  logic [NB-1:0]   en_mask, lane_en;
  logic [XLEN-1:0] wr_rep;

  always_comb begin
    misal   = 1'b0;
    en_mask = '0;
    wr_rep  = '0;
    case (mem_sz)
      2'd0: begin
        en_mask = NB'(1);
        wr_rep  = {NB{x_rs2[7:0]}};
      end
      2'd1: begin
        en_mask = NB'(3);
        wr_rep  = {(NB/2){x_rs2[15:0]}};
        misal   = sum_ri[0];
      end
      default: begin
        en_mask = NB'(15);
        wr_rep  = {(NB/4){x_rs2[31:0]}};
        misal   = |sum_ri[1:0];
      end
    endcase
    lane_en = misal ? '0 : (en_mask << sum_ri[OFFW-1:0]);
  end

  logic            mdu_wb;
  logic [XLEN-1:0] mdu_res;

`ifdef EXU_MDU_EN
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int CNTW = $clog2(XLEN) + 1;

  state_t            state, state_nxt;
  logic              is_m;
  logic [2:0]        m_code;
  logic              m_start, s1_en, s2_en, sgn1, sgn2, div0, ovf;
  logic [XLEN-1:0]   mag1, mag2;
  logic [2:0]        mop;
  logic [CNTW-1:0]   cnt;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   opd;
  logic              neg_q, neg_r;

  // m_code: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
  always_comb begin
    is_m   = 1'b1;
    m_code = 3'd0;
    case (instID)
      IDW'(`ID_MUL):    m_code = 3'd0;
      IDW'(`ID_MULH):   m_code = 3'd1;
      IDW'(`ID_MULHSU): m_code = 3'd2;
      IDW'(`ID_MULHU):  m_code = 3'd3;
      IDW'(`ID_DIV):    m_code = 3'd4;
      IDW'(`ID_DIVU):   m_code = 3'd5;
      IDW'(`ID_REM):    m_code = 3'd6;
      IDW'(`ID_REMU):   m_code = 3'd7;
      default:          is_m   = 1'b0;
    endcase
  end

  assign m_start = accept && is_m;
  assign s1_en   = (m_code == 3'd0) || (m_code == 3'd1) || (m_code == 3'd2) ||
                   (m_code == 3'd4) || (m_code == 3'd6);
  assign s2_en   = (m_code == 3'd0) || (m_code == 3'd1) || (m_code == 3'd4) || (m_code == 3'd6);
  assign sgn1    = s1_en && x_rs1[XLEN-1];
  assign sgn2    = s2_en && x_rs2[XLEN-1];
  assign mag1    = sgn1 ? -x_rs1 : x_rs1;
  assign mag2    = sgn2 ? -x_rs2 : x_rs2;
  assign div0    = m_code[2] && (x_rs2 == '0);
  assign ovf     = m_code[2] && s1_en && (x_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&x_rs2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m_start) state_nxt = (div0 || ovf) ? DONE : RUN;
      RUN:     if (cnt == CNTW'(1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Shift-add multiply: acc = {partial high, multiplier shifting out}.
  // Restoring divide:  acc = {remainder, dividend shifting into quotient}.
  logic [XLEN:0]     mul_sum, div_trial, div_diff;
  logic [2*XLEN-1:0] mul_step, div_step;
  assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : {(XLEN+1){1'b0}});
  assign mul_step  = {mul_sum, acc[XLEN-1:1]};
  assign div_trial = acc[2*XLEN-1:XLEN-1];
  assign div_diff  = div_trial - {1'b0, opd};
  assign div_step  = div_diff[XLEN] ? {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0],  acc[XLEN-2:0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mop   <= 3'd0;
      cnt   <= '0;
      acc   <= '0;
      opd   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (m_start) begin
      mop <= m_code;
      cnt <= CNTW'(XLEN);
      if (div0) begin
        acc   <= {x_rs1, {XLEN{1'b1}}};
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else if (ovf) begin
        acc   <= {{XLEN{1'b0}}, x_rs1};
        neg_q <= 1'b0;
        neg_r <= 1'b0;
      end else if (m_code[2]) begin
        acc   <= {{XLEN{1'b0}}, mag1};
        opd   <= mag2;
        neg_q <= sgn1 ^ sgn2;
        neg_r <= sgn1;
      end else begin
        acc   <= {{XLEN{1'b0}}, mag2};
        opd   <= mag1;
        neg_q <= sgn1 ^ sgn2;
        neg_r <= 1'b0;
      end
    end else if (state == RUN) begin
      cnt <= cnt - CNTW'(1);
      acc <= mop[2] ? div_step : mul_step;
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  assign prod = neg_q ? -acc : acc;
  assign quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem  = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    case (mop)
      3'd0:       mdu_res = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       mdu_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: mdu_res = quo;
      default:    mdu_res = rem;
    endcase
  end

  assign mdu_wb = (state == DONE) && !flush;
  assign in_rdy = (state == IDLE);
  assign busy   = (state != IDLE);
`else
  assign mdu_wb  = 1'b0;
  assign mdu_res = '0;
  assign in_rdy  = 1'b1;
  assign busy    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_jmp_vld    <= 1'b0;
      ex_jmp_addr   <= PC_RST;
      ex_rd_vld     <= 1'b0;
      ex_rd         <= PC_RST;
      ex_mem_addr   <= '0;
      ex_mem_rden   <= '0;
      ex_mem_wren   <= '0;
      ex_mem_wrdata <= '0;
      ex_ld_sext    <= 2'd0;
      ex_misalign   <= 1'b0;
    end else begin
      ex_jmp_vld  <= 1'b0;
      ex_rd_vld   <= 1'b0;
      ex_mem_rden <= '0;
      ex_mem_wren <= '0;
      ex_misalign <= 1'b0;
      if (mdu_wb) begin
        ex_rd_vld <= 1'b1;
        ex_rd     <= mdu_res;
      end else if (accept) begin
        ex_rd_vld  <= n_rd_vld;
        ex_jmp_vld <= n_jmp_vld;
        if (n_rd_vld)  ex_rd       <= n_rd;
        if (n_jmp_vld) ex_jmp_addr <= n_jmp_addr;
        if (mem_op) begin
          ex_mem_addr <= sum_ri;
          ex_misalign <= misal;
          if (mem_st) begin
            ex_mem_wren   <= lane_en;
            ex_mem_wrdata <= wr_rep;
          end else begin
            ex_mem_rden <= lane_en;
            ex_ld_sext  <= mem_fmt;
          end
        end
      end
    end
  end

endmodule

// File: doc/execute_unit_mc.md
Name: execute_unit_mc

Overview:
- Parametrised, multi-cycle successor of the single-cycle execute stage. Sits between decode and MEM.
- Executes integer ALU ops (now including shifts, SLT, OR, XOR), branches and JALR, and LB/LH/LW/LBU/LHU/SB/SH/SW with byte enables.
- Adds an iterative multiply/divide engine. Because of this, it uses an in_vld/in_rdy handshake and stalls decode while the engine runs.

Parameters:
- XLEN, 32, datapath width. Must be 32 or 64; byte lanes = XLEN/8.
- IDW, 6, width of instID. Op encodings are the ID_* macros in defines.v.
- PC_RST, 0, value driven on ex_jmp_addr and ex_rd while in reset.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_vld  in  1  decoded instruction valid
- in_rdy  out  1  unit can accept; equals (state==IDLE)
- flush  in  1  kill in-flight op (branch taken upstream)
- instID  in  IDW  operation ID
- x_rs1, x_rs2  in  XLEN  source operands
- imm  in  XLEN  sign-extended immediate
- pc  in  XLEN  instruction PC
- ex_jmp_vld  out  1  taken branch/JALR, one-cycle pulse
- ex_jmp_addr  out  XLEN  jump target
- ex_rd_vld  out  1  writeback valid, one-cycle pulse
- ex_rd  out  XLEN  writeback data
- ex_mem_addr  out  XLEN  byte address
- ex_mem_rden  out  XLEN/8  load byte enables
- ex_mem_wren  out  XLEN/8  store byte enables
- ex_mem_wrdata  out  XLEN  store data, lane-aligned
- ex_ld_sext  out  2  load format for MEM: 0 = word, 1 = signed byte/half, 2 = unsigned byte/half
- ex_misalign  out  1  misaligned access pulse; no enables asserted
- busy  out  1  MDU engine running

Behaviour:
- Reset (async, rst_n=0):
  - all valid/pulse outputs, enables and busy are 0; state = IDLE.
  - ex_jmp_addr and ex_rd = PC_RST; other data outputs are 0.
- Pulse outputs (ex_jmp_vld, ex_rd_vld, rden, wren, ex_misalign) default to 0 every cycle. Data outputs hold their value when not updated.
- Single-cycle ops:
  - Accepted when in_vld && in_rdy; result registered on the next edge (latency 1).
  - Arithmetic is modulo 2^XLEN.
  - Shift amount = low log2(XLEN) bits of the operand; SRA/SRAI are arithmetic.
  - Branch target = pc + imm. JALR target = (x_rs1 + imm) & ~1, with ex_rd = pc + 4.
  - JAL writes only pc + 4 to ex_rd. Its jump is resolved upstream.
- Memory ops:
  - addr = x_rs1 + imm.
  - Enables are shifted by addr[log2(XLEN/8)-1:0]; store data is replicated into the lanes.
  - Halfword on an odd address, or word on an address not 4-aligned: ex_misalign=1 and no enables.
- MDU FSM states: IDLE -> RUN -> DONE -> IDLE.
  - MUL/MULH/MULHSU/MULHU use shift-add; DIV/DIVU/REM/REMU use restoring division.
  - Accept edge moves IDLE -> RUN; counter loads XLEN; in_rdy drops next cycle; busy=1.
  - One bit per cycle in RUN; at counter 0 go to DONE.
  - DONE registers ex_rd with ex_rd_vld=1 for one cycle, then returns to IDLE.
  - Total latency from accept edge to ex_rd_vld is XLEN+2 cycles.
  - Signed ops take magnitudes first and fix the sign in DONE.
- Division corner cases:
  - Divide by zero: quotient = all ones, remainder = dividend. Takes 1 cycle (IDLE -> DONE directly).
  - Signed overflow (most-negative / -1): quotient = dividend, remainder = 0. Also takes 1 cycle.
- flush:
  - In RUN or DONE: next state IDLE, no ex_rd_vld.
  - Simultaneous with in_vld: the instruction is dropped.
  - flush has priority over everything except reset.
- Unknown instID: accepted and produces no outputs.
- rs1 == rs2 register aliasing needs no special handling.

Optional Feature:
- EXU_MDU_EN defined: MDU engine and M-extension IDs are implemented as above.
- Not defined: M IDs behave as unknown IDs; in_rdy is tied to 1; busy is tied to 0; no FSM logic is synthesised.

Test Plan:
- XLEN=32: ADDI x_rs1=0x7FFFFFFF, imm=1 -> next cycle ex_rd_vld=1, ex_rd=0x80000000.
- SRA x_rs1=0x80000000, x_rs2=0x21 -> ex_rd=0xC0000000; BLT rs1=-1, rs2=0, pc=0x100, imm=-8 -> ex_jmp_vld=1, ex_jmp_addr=0xF8.
- SB addr=0x1003, x_rs2=0xAB -> wren=4'b1000, wrdata=0xABABABAB; LH addr=0x1001 -> ex_misalign=1, rden=0.
- DIV -7/2 -> in_rdy low for 33 cycles, ex_rd=0xFFFFFFFD at cycle 34; REM -> 0xFFFFFFFF; DIVU 5/0 -> ex_rd=0xFFFFFFFF 2 cycles after accept.
- MULH 0x80000000 x 0x80000000 -> ex_rd=0x40000000; flush asserted at RUN cycle 10 -> no ex_rd_vld, in_rdy=1 next cycle.
- rst_n deasserted mid-RUN -> busy=0, in_rdy=1 immediately (async); with EXU_MDU_EN undefined, DIV -> no outputs, in_rdy stays 1.
